// File: rtl/video_timing_pkg.sv
// Shared 640x480 timing constants, coordinate/pixel widths and receiver state encoding.
// Used by both the timing generator and video_timing_rx.
package video_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W  = 12;
    localparam int PIX_W    = 32;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/video_rx_measure.sv
// Timing measurement counters for video_timing_rx (built only with VIDEO_RX_MEASURE_EN).
module video_rx_measure (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_edge,
    input  logic        vs_edge,
    input  logic        de_fall,
    input  logic [11:0] line_width,
    input  logic [11:0] frame_lines,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_v_active
);
    import video_timing_pkg::*;

    logic [1:0]  vs_seen;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        pub;

    // Nothing is published until one complete frame has been bracketed by VS edges.
    assign pub = (vs_seen == 2'd2) || (vs_seen == 2'd1 && vs_edge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_seen       <= 2'd0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            meas_h_total  <= '0;
            meas_v_total  <= '0;
            meas_h_active <= '0;
            meas_v_active <= '0;
        end else begin
            h_cnt <= hs_edge ? 12'd1 : sat_inc(h_cnt);
            if (vs_edge)
                v_cnt <= hs_edge ? 12'd1 : 12'd0;
            else if (hs_edge)
                v_cnt <= sat_inc(v_cnt);
            if (vs_edge && vs_seen != 2'd2)
                vs_seen <= vs_seen + 2'd1;
            if (pub) begin
                if (hs_edge) meas_h_total  <= h_cnt;
                if (de_fall) meas_h_active <= line_width;
                if (vs_edge) begin
                    meas_v_total  <= v_cnt;
                    meas_v_active <= frame_lines;
                end
            end
        end
    end

endmodule

// File: rtl/video_timing_rx.sv
// Video receive front end: position recovery, geometry lock and {00,b,g,r} pixel packing.
// Define VIDEO_RX_MEASURE_EN to build the meas_* timing counters; otherwise they read 0.
module video_timing_rx #(
    parameter int   H_ACTIVE = video_timing_pkg::H_ACTIVE,
    parameter int   V_ACTIVE = video_timing_pkg::V_ACTIVE,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic [7:0]  rgb_r,
    input  logic [7:0]  rgb_g,
    input  logic [7:0]  rgb_b,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        locked,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_v_active
);
    import video_timing_pkg::*;

    localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACTIVE);

    logic hs_q, vs_q, de_q, hs_d, vs_d, de_d;
    rgb_t rgb_q;
    logic hs_edge, vs_edge, de_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
            rgb_q <= '0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            de_d  <= 1'b0;
        end else begin
            hs_q  <= hs;
            vs_q  <= vs;
            de_q  <= de;
            rgb_q <= '{b: rgb_b, g: rgb_g, r: rgb_r};
            hs_d  <= hs_q;
            vs_d  <= vs_q;
            de_d  <= de_q;
        end
    end

    assign hs_edge = (hs_q == HS_POL) && (hs_d != HS_POL);
    assign vs_edge = (vs_q == VS_POL) && (vs_d != VS_POL);
    assign de_fall = de_d && !de_q;

    // Position and geometry tracking
    logic [COORD_W-1:0] x_cnt, y_cnt, y_cur, lines_now;
    logic               bad, line_bad, frame_ok;

    // A VS edge landing on a pixel makes that pixel row 0.
    assign y_cur     = vs_edge ? '0 : y_cnt;
    assign lines_now = de_fall ? sat_inc(y_cnt) : y_cnt;
    assign line_bad  = de_fall && (x_cnt != H_ACT_C);
    assign frame_ok  = !(bad || line_bad) && (lines_now == V_ACT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            bad   <= 1'b0;
        end else begin
            x_cnt <= de_q ? sat_inc(x_cnt) : '0;
            if (vs_edge) begin
                y_cnt <= '0;
                bad   <= 1'b0;
            end else begin
                if (de_fall)  y_cnt <= sat_inc(y_cnt);
                if (line_bad) bad   <= 1'b1;
            end
        end
    end

    // Lock FSM
    rx_state_e state, state_nx;
    logic      err_nx, cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        cnt_inc  = 1'b0;
        if (vs_edge) begin
            case (state)
                SEARCH: state_nx = SYNC;
                SYNC: begin
                    if (frame_ok) state_nx = LOCKED;
                    else          err_nx   = 1'b1;
                end
                LOCKED: begin
                    if (frame_ok) begin
                        cnt_inc = 1'b1;
                    end else begin
                        state_nx = SYNC;
                        err_nx   = 1'b1;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    assign locked = (state == LOCKED);

    // Output stage; next-state lock lets the frame that gains lock emit row 0.
    logic pix_ok;
    assign pix_ok = de_q && (state_nx == LOCKED) && (x_cnt < H_ACT_C) && (y_cur < V_ACT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pix_valid <= pix_ok;
            pix_sof   <= pix_ok && (x_cnt == '0) && (y_cur == '0);
            pix_eol   <= pix_ok && (x_cnt == H_ACT_C - 1'b1);
            if (pix_ok) begin
                pix_x    <= x_cnt;
                pix_y    <= y_cur;
                pix_data <= {8'h00, rgb_q};
            end
            frame_err <= err_nx;
            if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef VIDEO_RX_MEASURE_EN
    video_rx_measure u_measure (
        .clk           (clk),
        .rst_n         (rst_n),
        .hs_edge       (hs_edge),
        .vs_edge       (vs_edge),
        .de_fall       (de_fall),
        .line_width    (x_cnt),
        .frame_lines   (lines_now),
        .meas_h_total  (meas_h_total),
        .meas_v_total  (meas_v_total),
        .meas_h_active (meas_h_active),
        .meas_v_active (meas_v_active)
    );
`else
    logic unused_hs_edge;
    assign unused_hs_edge = hs_edge;
    assign meas_h_total   = '0;
    assign meas_v_total   = '0;
    assign meas_h_active  = '0;
    assign meas_v_active  = '0;
`endif

endmodule

// File: tb/tb_video_timing_rx.sv
// Scoreboard bench for video_timing_rx on a scaled-down 16x6 raster (28 clks x 11 lines).
module tb_video_timing_rx;
    localparam int HA  = 16;
    localparam int VA  = 6;
    localparam int HFP = 6;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int HT  = HA + HFP + HSY + HBP;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        hs = 1'b1, vs = 1'b1, de = 1'b0;
    logic [7:0]  rgb_r = '0, rgb_g = '0, rgb_b = '0;
    logic [31:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol, locked, frame_err;
    logic [11:0] pix_x, pix_y;
    logic [15:0] frame_cnt;
    logic [11:0] meas_h_total, meas_v_total, meas_h_active, meas_v_active;

    typedef struct {
        logic [31:0] d;
        int          x;
        int          y;
        bit          sof;
        bit          eol;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   tests = 0, fails = 0, err_seen = 0;

    video_timing_rx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_x(pix_x), .pix_y(pix_y), .locked(locked), .frame_err(frame_err),
        .frame_cnt(frame_cnt),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total),
        .meas_h_active(meas_h_active), .meas_v_active(meas_v_active)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One raster line; expected pixels are queued as they are driven.
    task automatic drive_line(input bit vsa, input int w, input int y, input int fid,
                              input bit push, input int ncyc);
        for (int h = 0; h < ncyc; h++) begin
            @(posedge clk); #1;
            de    = (h < w);
            hs    = !(h >= HA + HFP && h < HA + HFP + HSY);
            vs    = !vsa;
            rgb_r = 8'(h);
            rgb_g = 8'(y);
            rgb_b = 8'(fid);
            if (de && push && h < HA && y < VA) begin
                exp_t e;
                e.d   = {8'h00, 8'(fid), 8'(y), 8'(h)};
                e.x   = h;
                e.y   = y;
                e.sof = (h == 0 && y == 0);
                e.eol = (h == HA - 1);
                q.push_back(e);
            end
        end
    endtask

    // mode 0: vsync, bp, active, fp. mode 1: vsync starts with first de. mode 2: no vsync.
    task automatic frame(input int nl, input int bl, input int bw, input int fid,
                         input bit ev, input int mode);
        if (mode == 1) begin
            for (int i = 0; i < nl; i++) drive_line(i < 2, (i == bl) ? bw : HA, i, fid, ev, HT);
            for (int i = 0; i < 5; i++)  drive_line(1'b0, 0, 0, fid, 1'b0, HT);
        end else begin
            for (int i = 0; i < 4; i++)  drive_line(mode == 0 && i < 2, 0, 0, fid, 1'b0, HT);
            for (int i = 0; i < nl; i++) drive_line(1'b0, (i == bl) ? bw : HA, i, fid, ev, HT);
            drive_line(1'b0, 0, 0, fid, 1'b0, HT);
        end
    endtask

    task automatic frame_chk(input string tag, input int lk, input int cnt, input int errs);
        chk({tag, "_locked"}, locked, lk);
        chk({tag, "_frame_cnt"}, frame_cnt, cnt);
        chk({tag, "_frame_err_clks"}, err_seen, errs);
        chk({tag, "_pending_pixels"}, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (pix_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL pix_extra: got x=%0d y=%0d, expected no pixel", pix_x, pix_y);
                end else begin
                    m = q.pop_front();
                    if (pix_data !== m.d || int'(pix_x) != m.x || int'(pix_y) != m.y ||
                        pix_sof !== m.sof || pix_eol !== m.eol) begin
                        fails++;
                        $display("FAIL pix: got x=%0d y=%0d d=%h sof=%b eol=%b expected x=%0d y=%0d d=%h sof=%b eol=%b",
                                 pix_x, pix_y, pix_data, pix_sof, pix_eol, m.x, m.y, m.d, m.sof, m.eol);
                    end
                end
            end
        end
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_pix_flags", int'(pix_valid | pix_sof | pix_eol | frame_err), 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_meas", int'(meas_h_total | meas_v_total | meas_h_active | meas_v_active), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Acquire lock and stream good frames.
        frame(VA, -1, 0, 1, 1'b0, 0);  frame_chk("f1_sync", 0, 0, 0);
        frame(VA, -1, 0, 2, 1'b1, 0);  frame_chk("f2_lock", 1, 0, 0);
        frame(VA, -1, 0, 3, 1'b1, 0);  frame_chk("f3", 1, 1, 0);
        frame(VA, -1, 0, 4, 1'b1, 0);  frame_chk("f4", 1, 2, 0);
        // Short line while locked; error surfaces at the next VS edge.
        frame(VA, 2, HA - 1, 5, 1'b1, 0); frame_chk("f5_short", 1, 3, 0);
        frame(VA, -1, 0, 6, 1'b0, 0);  frame_chk("f6_unlock", 0, 3, 1);
        frame(VA, -1, 0, 7, 1'b1, 0);  frame_chk("f7_relock", 1, 3, 1);
        // Extra line plus an over-wide line.
        frame(VA + 1, 1, HA + 6, 8, 1'b1, 0); frame_chk("f8_overrun", 1, 4, 1);
        frame(VA, -1, 0, 9, 1'b0, 0);  frame_chk("f9_unlock", 0, 4, 2);
        // VS edge on the first de cycle of a frame that gains lock.
        frame(VA, -1, 0, 10, 1'b1, 1); frame_chk("f10_vs_de", 1, 4, 2);
        frame(VA, -1, 0, 11, 1'b1, 0); frame_chk("f11", 1, 5, 2);

        // Async reset in the middle of a locked line.
        for (int i = 0; i < 4; i++) drive_line(i < 2, 0, 0, 12, 1'b0, HT);
        drive_line(1'b0, HA, 0, 12, 1'b1, HT);
        drive_line(1'b0, HA, 1, 12, 1'b1, HT);
        drive_line(1'b0, HA, 2, 12, 1'b1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pix_flags", int'(pix_valid | pix_sof | pix_eol | locked | frame_err), 0);
        chk("arst_pix_xy", int'(pix_x | pix_y), 0);
        chk("arst_pix_data", pix_data, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        q.delete();
        de = 1'b0; vs = 1'b1; hs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        frame(3, -1, 0, 13, 1'b0, 2);  frame_chk("f13_partial", 0, 0, 2);
        frame(VA, -1, 0, 14, 1'b0, 0); frame_chk("f14_sync", 0, 0, 2);
        frame(VA, -1, 0, 15, 1'b1, 0); frame_chk("f15_lock", 1, 0, 2);
        drive_line(1'b1, 0, 0, 0, 1'b0, HT);
        drive_line(1'b1, 0, 0, 0, 1'b0, HT);
        drive_line(1'b0, 0, 0, 0, 1'b0, HT);
        frame_chk("tail", 1, 1, 2);

`ifdef VIDEO_RX_MEASURE_EN
        chk("meas_h_total", meas_h_total, HT);
        chk("meas_v_total", meas_v_total, 11);
        chk("meas_h_active", meas_h_active, HA);
        chk("meas_v_active", meas_v_active, VA);
`else
        chk("meas_h_total", meas_h_total, 0);
        chk("meas_v_total", meas_v_total, 0);
        chk("meas_h_active", meas_h_active, 0);
        chk("meas_v_active", meas_v_active, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
